seq_sub_divider8: RTL and testbench

// - Multi-cycle unsigned integer divider, built on one WIDTH-bit subtractor (restoring division).
// - Computes quotient and remainder of dividend/divisor, one quotient bit per clock.
// - Complements the combinational adder datapath.
// - Start/done handshake; results held until the next accepted start.

---
 rtl/seq_sub_divider8.sv | 140 ++++++++++++++
 tb/tb_seq_sub_divider8.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_sub_divider8.sv
// seq_sub_divider8: multi-cycle restoring divider, one quotient bit per clock,
// built around a single WIDTH+1-bit compare/subtract.
// Optional feature: define DIV_SIGNED_EN for two's-complement operands
// (adds a FIX state that applies the result signs; latency WIDTH+2).
module seq_sub_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_r;     // dividend shift register, becomes the quotient
  logic [WIDTH-1:0] r_r;     // partial remainder; always < divisor so WIDTH bits hold it
  logic [WIDTH-1:0] dvs;     // latched divisor (magnitude in signed mode)
  logic [CW-1:0]    cnt;
  logic             fin;     // last iteration done, results ready to publish
  logic             dz;      // divisor was zero at accept
  logic [WIDTH:0]   rs;      // shifted partial remainder R'
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic             accept;
  logic [WIDTH-1:0] dnd_ld;
  logic [WIDTH-1:0] dvs_ld;
`ifdef DIV_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
`endif

  // Datapath: one shift/compare/subtract step plus operand conditioning at accept
  always_comb begin
    rs     = {r_r, q_r[WIDTH-1]};
    ge     = (rs >= {1'b0, dvs});
    // when ge holds the difference is < divisor, so the low WIDTH bits are exact
    diff   = rs[WIDTH-1:0] - dvs;
    accept = start && (state == IDLE || state == DONE);
`ifdef DIV_SIGNED_EN
    dnd_ld = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_ld = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    dnd_ld = dividend;
    dvs_ld = divisor;
`endif
    // divide-by-zero reports the raw dividend as remainder, so keep it unmodified
    if (divisor == '0) dnd_ld = dividend;
  end

  // Control FSM, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      q_r       <= '0;
      r_r       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      fin       <= 1'b0;
      dz        <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            q_r      <= dnd_ld;
            r_r      <= '0;
            dvs      <= dvs_ld;
            cnt      <= CW'(WIDTH-1);
            dz       <= (divisor == '0);
            // a zero divisor skips the iterations and publishes on the next edge
            fin      <= (divisor == '0);
            busy     <= (divisor != '0);
            div_zero <= 1'b0;
            state    <= RUN;
`ifdef DIV_SIGNED_EN
            neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r    <= dividend[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (!fin) begin
            q_r <= {q_r[WIDTH-2:0], ge};
            r_r <= ge ? diff : rs[WIDTH-1:0];
            if (cnt == '0) begin
              fin  <= 1'b1;
              busy <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end else begin
            fin <= 1'b0;
`ifdef DIV_SIGNED_EN
            if (!dz) begin
              state <= FIX;
              q_r   <= neg_q ? -q_r : q_r;
              r_r   <= neg_r ? -r_r : r_r;
            end else
`endif
            begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= dz ? '1 : q_r;
              remainder <= dz ? q_r : r_r;
              div_zero  <= dz;
            end
          end
        end
        FIX: begin
          state     <= DONE;
          done      <= 1'b1;
          quotient  <= q_r;
          remainder <= r_r;
          div_zero  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_sub_divider8.sv
// Scoreboard bench for seq_sub_divider8: stimulus pushes expected results,
// a monitor pops and compares whenever done is seen.
module tb_seq_sub_divider8;
  localparam int W = 8;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           t;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  seq_sub_divider8 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // drive one start pulse at a negedge; sampled at the next posedge (cycle cyc+1)
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic push,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                       input int elat);
    exp_t e;
    start = 1'b1; dividend = a; divisor = b;
    if (push) begin
      e = '{eq, er, edz, cyc + 1, elat};
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got=no done want=done within 40 cycles");
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                     input int elat);
    issue(a, b, 1'b1, eq, er, edz, elat);
    wait_done();
    @(negedge clk);
  endtask

  // Monitor: compare every done against the oldest expectation
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_done: got=done want=no done (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_zero", div_zero, e.dz);
          chk("latency", cyc - e.t, e.lat);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DIV_SIGNED_EN
    run(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, LAT);   // -7/2
    run(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT);   // overflow case
    run(8'd7,  8'hFE, 8'hFD, 8'h01, 1'b0, LAT);   // 7/-2
    run(8'd37, 8'd0,  8'hFF, 8'd37, 1'b1, 1);
    issue(8'd100, 8'd3, 1'b1, 8'd33, 8'd1, 1'b0, LAT);
    chk("div_zero_clr", div_zero, 0);
    wait_done();
    @(negedge clk);
`else
    run(8'd200, 8'd7,   8'd28,  8'd4, 1'b0, LAT);
    run(8'd5,   8'd9,   8'd0,   8'd5, 1'b0, LAT);
    run(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, LAT);
    run(8'd255, 8'd255, 8'd1,   8'd0, 1'b0, LAT);
    repeat (3) @(negedge clk);
    chk("hold_quotient", quotient, 1);
    chk("hold_remainder", remainder, 0);
    chk("hold_done_low", done, 0);

    run(8'd37, 8'd0, 8'd255, 8'd37, 1'b1, 1);
    chk("hold_div_zero", div_zero, 1);
    issue(8'd10, 8'd3, 1'b1, 8'd3, 8'd1, 1'b0, LAT);
    chk("div_zero_clr", div_zero, 0);
    chk("busy_run", busy, 1);
    wait_done();
    @(negedge clk);

    // start while busy is ignored; start in the done cycle is accepted
    issue(8'd100, 8'd3, 1'b1, 8'd33, 8'd1, 1'b0, LAT);
    @(negedge clk);
    chk("busy_mid", busy, 1);
    issue(8'd9, 8'd2, 1'b0, '0, '0, 1'b0, 0);
    wait_done();
    issue(8'd9, 8'd2, 1'b1, 8'd4, 8'd1, 1'b0, LAT);
    wait_done();
    @(negedge clk);

    // reset mid-divide: no done, outputs cleared
    issue(8'd200, 8'd7, 1'b0, '0, '0, 1'b0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_div_zero", div_zero, 0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    run(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, LAT);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
